pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer, successor to the basic fetch PC. It generates the fetch address each cycle and supports fetch stall, absolute jump, PC-relative branch, and call/return through an internal circular return-address stack (RAS). It sits at the head of the fetch stage and feeds `pc` to instruction memory.

## Interface
- `WIDTH`, default 16: address width in bits.
- `STEP`, default 2: bytes per instruction. Must be a power of two, ≥1.
- `RESET_VECTOR`, default 0: `pc` value after reset. Must be STEP-aligned.
- `RAS_DEPTH`, default 8: return-stack entries. Must be ≥2 and a power of two.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (asserts while 0).
- `stall`  in  1: hold all state this cycle.
- `jump_en`  in  1: absolute jump to `target`.
- `branch_en`  in  1: relative branch, `pc + offset`.
- `call_en`  in  1: jump to `target` and push `pc + STEP`.
- `ret_en`  in  1: pop the RAS top into `pc`.
- `target`  in  WIDTH: absolute destination for jump/call.
- `offset`  in  WIDTH: two's-complement byte offset for branch.
- `err_clear`  in  1: clear the sticky error flags.
- `pc`  out  WIDTH: current fetch address (registered).
- `ras_count`  out  $clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_overflow`  out  1: sticky; a push occurred while the RAS was full.
- `ras_underflow`  out  1: sticky; a pop occurred while the RAS was empty.

## Operation
- Next-PC priority, highest first: `stall` > `ret_en` > `call_en` > `jump_en` > `branch_en` > sequential (`pc + STEP`).
- Only the winning request acts. Lower-priority requests in the same cycle are ignored, with no side effects.
- `stall=1`: `pc`, RAS contents, `ras_count` and the flags all hold. Exception: `err_clear` still takes effect.
- Alignment: every loaded target (`target`, `pc+offset`, popped value) has its low log2(STEP) bits forced to 0.
- All address arithmetic is modulo 2^WIDTH; wrap-around is silent. Example: WIDTH=16, STEP=2, `pc`=0xFFFE sequential → 0x0000.
- Call:
  - `pc` ← aligned `target`.
  - Push `pc + STEP` (mod 2^WIDTH) onto the RAS.
- Return:
  - If `ras_count` > 0: `pc` ← top entry; `ras_count` decrements.
- RAS structure: circular buffer with a top pointer; `ras_count` saturates at RAS_DEPTH.
- Push when full:
  - Overwrite the oldest entry; the top pointer advances.
  - `ras_count` stays at RAS_DEPTH.
  - `ras_overflow` ← 1.
  - The newest RAS_DEPTH return addresses remain poppable in LIFO order.
- Pop when empty:
  - `pc` ← `pc + STEP`.
  - `ras_underflow` ← 1.
  - `ras_count` stays 0; the pointer does not move.
- `err_clear=1`: both flags ← 0 on that edge. If an error event occurs on the same edge, the set wins (flag = 1).
- Reset, asynchronous and active at any time including mid-call:
  - `pc` ← RESET_VECTOR; `ras_count` ← 0; top pointer ← 0; flags ← 0.
  - RAS storage contents need not be cleared; they are unreachable while `ras_count` = 0.

## Timing
- Latency: every request is sampled at rising edge N and is visible on `pc` immediately after edge N. `pc` is a register output with no combinational path from inputs.
- Back-to-back call/ret on consecutive cycles is fully supported, with no bubble.
- After reset deasserts (`reset` 0→1), the first rising edge advances `pc` to RESET_VECTOR+STEP unless stalled or redirected.
- `ras_count` and the flags update on the same edge as `pc`.

## Test plan
- Reset, then 3 free-running cycles, WIDTH=16, STEP=2, RESET_VECTOR=0x0100 → `pc` = 0x0100, 0x0102, 0x0104, 0x0106. Drive `reset` low mid-run → `pc` = 0x0100 immediately, without a clock edge.
- At `pc`=0x0010: `branch_en`, `offset`=0xFFF0 → `pc`=0x0000. Then `jump_en`, `target`=0x1235 → `pc`=0x1234. `stall` for 2 cycles → `pc` holds at 0x1234.
- At `pc`=0x0040: call to 0x0200 → `pc`=0x0200, `ras_count`=1. Two sequential cycles, then `ret_en` → `pc`=0x0042, `ras_count`=0.
- RAS_DEPTH=8: 9 nested calls from distinct PCs → `ras_overflow`=1, `ras_count`=8. 8 returns yield return addresses #9 down to #2 in order. A 9th return → `ras_underflow`=1, `pc` = previous `pc`+2.
- Same cycle `ret_en`+`call_en`+`jump_en` with `ras_count`=1 → pop only; `pc` = stacked value, `ras_count`=0, no push. `err_clear` together with an underflow event → `ras_underflow` stays 1. `err_clear` alone next cycle → 0.
- `pc`=0xFFFE sequential → `pc`=0x0000. A call at `pc`=0xFFFE pushes 0x0000; the matching return → `pc`=0x0000.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Redirect request bundle from the fetch controller into pc_sequencer.
// Master drives control-flow requests; slave is the sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             jump_en;
    logic             branch_en;
    logic             call_en;
    logic             ret_en;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] offset;

    modport master (
        output stall, jump_en, branch_en, call_en, ret_en, target, offset
    );

    modport slave (
        input stall, jump_en, branch_en, call_en, ret_en, target, offset
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch program counter with jump/branch/call/return and a circular
// return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
    parameter int               WIDTH        = 16,
    parameter int               STEP         = 2,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    pc_sequencer_if.slave                bus,
    input  logic                         err_clear,
    output logic [WIDTH-1:0]             pc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    localparam int AW = $clog2(RAS_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [WIDTH-1:0] INC   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN = ~(WIDTH'(STEP - 1));
    localparam logic [CW-1:0]    FULL  = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [AW-1:0]    top, top_n;
    logic [CW-1:0]    cnt_n;
    logic [WIDTH-1:0] pc_n;
    logic [WIDTH-1:0] seq_pc;
    logic             push;
    logic             ovf_set;
    logic             unf_set;

    assign seq_pc = pc + INC;

    // Priority chain: stall, ret, call, jump, branch, sequential.
    always_comb begin
        pc_n    = pc;
        cnt_n   = ras_count;
        top_n   = top;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (bus.stall) begin
            pc_n = pc;
        end else if (bus.ret_en) begin
            if (ras_count != '0) begin
                pc_n  = stack[top] & ALIGN;
                top_n = top - 1'b1;
                cnt_n = ras_count - 1'b1;
            end else begin
                pc_n    = seq_pc;
                unf_set = 1'b1;
            end
        end else if (bus.call_en) begin
            pc_n  = bus.target & ALIGN;
            push  = 1'b1;
            top_n = top + 1'b1;
            if (ras_count == FULL) begin
                ovf_set = 1'b1;
            end else begin
                cnt_n = ras_count + 1'b1;
            end
        end else if (bus.jump_en) begin
            pc_n = bus.target & ALIGN;
        end else if (bus.branch_en) begin
            pc_n = (pc + bus.offset) & ALIGN;
        end else begin
            pc_n = seq_pc;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc            <= RESET_VECTOR;
            ras_count     <= '0;
            top           <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_n;
            ras_count     <= cnt_n;
            top           <= top_n;
            ras_overflow  <= ovf_set | (ras_overflow & ~err_clear);
            ras_underflow <= unf_set | (ras_underflow & ~err_clear);
        end
    end

    // Storage is never cleared; ras_count gates what is reachable.
    always_ff @(posedge clock) begin
        if (push) begin
            stack[top_n] <= seq_pc;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pc_sequencer;
    localparam int          W     = 16;
    localparam int          DEPTH = 8;
    localparam logic [15:0] RV    = 16'h0100;

    logic        clock;
    logic        reset;
    logic        err_clear;
    logic [15:0] pc;
    logic [3:0]  ras_count;
    logic        ras_overflow;
    logic        ras_underflow;

    int n_cmp;
    int n_bad;

    logic [15:0] m_pc;
    logic [15:0] m_ras[$];
    bit          m_ovf;
    bit          m_unf;

    pc_sequencer_if #(.WIDTH(W)) bus ();

    pc_sequencer #(
        .WIDTH(W), .STEP(2), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .err_clear(err_clear),
        .pc(pc),
        .ras_count(ras_count),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        bus.stall = 0; bus.jump_en = 0; bus.branch_en = 0;
        bus.call_en = 0; bus.ret_en = 0; err_clear = 0;
        bus.target = 16'h0; bus.offset = 16'h0;
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_ras.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Behavioural next state from the current request inputs.
    task automatic model_step();
        bit o, u;
        o = 0; u = 0;
        if (!bus.stall) begin
            if (bus.ret_en) begin
                if (m_ras.size() > 0) m_pc = m_ras.pop_back() & 16'hFFFE;
                else begin m_pc = m_pc + 16'd2; u = 1; end
            end else if (bus.call_en) begin
                m_ras.push_back(m_pc + 16'd2);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    o = 1;
                end
                m_pc = bus.target & 16'hFFFE;
            end else if (bus.jump_en) begin
                m_pc = bus.target & 16'hFFFE;
            end else if (bus.branch_en) begin
                m_pc = (m_pc + bus.offset) & 16'hFFFE;
            end else begin
                m_pc = m_pc + 16'd2;
            end
        end
        m_ovf = o | (m_ovf & !err_clear);
        m_unf = u | (m_unf & !err_clear);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic do_jump(input logic [15:0] t);
        bus.jump_en = 1; bus.target = t;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        reset = 0;
        idle();
        model_reset();
        #12;
        n_cmp++;
        if (pc !== RV || ras_count !== 4'd0 || ras_overflow !== 1'b0 ||
            ras_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state pc=%h cnt=%0d ovf=%b unf=%b want pc=%h",
                     pc, ras_count, ras_overflow, ras_underflow, RV);
        end
        @(negedge clock);
        reset = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = RV + 16'(2 * i);
            n_cmp++;
            if (pc !== exp) begin
                n_bad++;
                $display("FAIL free_run_%0d pc=%h want %h", i, pc, exp);
            end
        end
        bus.call_en = 1; bus.target = 16'h0600;
        tick();
        #2;
        reset = 0;
        #1;
        model_reset();
        n_cmp++;
        if (pc !== RV || ras_count !== 4'd0) begin
            n_bad++;
            $display("FAIL async_reset pc=%h cnt=%0d want pc=%h cnt=0",
                     pc, ras_count, RV);
        end
        @(negedge clock);
        reset = 1;
        tick();
        n_cmp++;
        if (pc !== 16'h0102) begin
            n_bad++;
            $display("FAIL after_reset pc=%h want 0102", pc);
        end
    endtask

    task automatic test_branch_jump_stall();
        do_jump(16'h0010);
        bus.branch_en = 1; bus.offset = 16'hFFF0;
        tick();
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL branch_back pc=%h want 0000", pc);
        end
        do_jump(16'h1235);
        n_cmp++;
        if (pc !== 16'h1234) begin
            n_bad++;
            $display("FAIL jump_align pc=%h want 1234", pc);
        end
        for (int i = 0; i < 2; i++) begin
            bus.stall = 1; bus.jump_en = 1; bus.target = 16'h0888;
            tick();
            n_cmp++;
            if (pc !== 16'h1234) begin
                n_bad++;
                $display("FAIL stall_hold_%0d pc=%h want 1234", i, pc);
            end
        end
    endtask

    task automatic test_call_ret();
        do_jump(16'h0040);
        bus.call_en = 1; bus.target = 16'h0200;
        tick();
        n_cmp++;
        if (pc !== 16'h0200 || ras_count !== 4'd1) begin
            n_bad++;
            $display("FAIL call pc=%h cnt=%0d want 0200/1", pc, ras_count);
        end
        tick();
        tick();
        bus.ret_en = 1;
        tick();
        n_cmp++;
        if (pc !== 16'h0042 || ras_count !== 4'd0) begin
            n_bad++;
            $display("FAIL ret pc=%h cnt=%0d want 0042/0", pc, ras_count);
        end
    endtask

    task automatic test_overflow_underflow();
        logic [15:0] exp;
        do_jump(16'h0800);
        for (int i = 0; i < 9; i++) begin
            bus.call_en = 1; bus.target = 16'h1000 + 16'(i * 16);
            tick();
        end
        n_cmp++;
        if (ras_overflow !== 1'b1 || ras_count !== 4'd8) begin
            n_bad++;
            $display("FAIL overflow ovf=%b cnt=%0d want 1/8",
                     ras_overflow, ras_count);
        end
        for (int k = 0; k < 8; k++) begin
            bus.ret_en = 1;
            tick();
            exp = 16'h1002 + 16'((7 - k) * 16);
            n_cmp++;
            if (pc !== exp) begin
                n_bad++;
                $display("FAIL pop_%0d pc=%h want %h", k, pc, exp);
            end
        end
        bus.ret_en = 1;
        tick();
        n_cmp++;
        if (ras_underflow !== 1'b1 || pc !== 16'h1004 ||
            ras_count !== 4'd0) begin
            n_bad++;
            $display("FAIL underflow unf=%b pc=%h cnt=%0d want 1/1004/0",
                     ras_underflow, pc, ras_count);
        end
    endtask

    task automatic test_priority_clear();
        logic [15:0] p;
        err_clear = 1;
        tick();
        n_cmp++;
        if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_both ovf=%b unf=%b want 0/0",
                     ras_overflow, ras_underflow);
        end
        p = pc;
        bus.call_en = 1; bus.target = 16'h0300;
        tick();
        bus.ret_en = 1; bus.call_en = 1; bus.jump_en = 1;
        bus.target = 16'h0700;
        tick();
        n_cmp++;
        if (pc !== p + 16'd2 || ras_count !== 4'd0 ||
            ras_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ret_wins pc=%h cnt=%0d want %h/0",
                     pc, ras_count, p + 16'd2);
        end
        bus.ret_en = 1; err_clear = 1;
        tick();
        n_cmp++;
        if (ras_underflow !== 1'b1 || pc !== p + 16'd4) begin
            n_bad++;
            $display("FAIL set_beats_clear unf=%b pc=%h want 1/%h",
                     ras_underflow, pc, p + 16'd4);
        end
        err_clear = 1;
        tick();
        n_cmp++;
        if (ras_underflow !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_alone unf=%b want 0", ras_underflow);
        end
    endtask

    task automatic test_wrap();
        do_jump(16'hFFFE);
        tick();
        n_cmp++;
        if (pc !== 16'h0000) begin
            n_bad++;
            $display("FAIL seq_wrap pc=%h want 0000", pc);
        end
        do_jump(16'hFFFE);
        bus.call_en = 1; bus.target = 16'h0500;
        tick();
        bus.ret_en = 1;
        tick();
        n_cmp++;
        if (pc !== 16'h0000 || ras_count !== 4'd0) begin
            n_bad++;
            $display("FAIL call_wrap pc=%h cnt=%0d want 0000/0",
                     pc, ras_count);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 15);
            bus.stall     = (r == 0);
            bus.ret_en    = ($urandom_range(0, 3) == 0);
            bus.call_en   = ($urandom_range(0, 3) == 0);
            bus.jump_en   = ($urandom_range(0, 7) == 0);
            bus.branch_en = ($urandom_range(0, 5) == 0);
            err_clear     = ($urandom_range(0, 15) == 0);
            bus.target    = 16'($urandom);
            bus.offset    = 16'($urandom);
            tick();
            n_cmp++;
            if (pc !== m_pc || ras_count !== 4'(m_ras.size()) ||
                ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                n_bad++;
                $display("FAIL random_%0d pc=%h cnt=%0d o=%b u=%b want %h/%0d/%b/%b",
                         i, pc, ras_count, ras_overflow, ras_underflow,
                         m_pc, m_ras.size(), m_ovf, m_unf);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_branch_jump_stall();
        test_call_ret();
        test_overflow_underflow();
        test_priority_clear();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
